// File: rtl/div_seq.sv
// Sequential 32-bit integer divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Latency: o_valid 33 cycles after accept for normal ops, 1 cycle after accept for divide-by-zero / signed overflow.
// Backpressure: o_stall holds the pipeline from the accept cycle through CALC; i_start outside IDLE is ignored.
//
// Ports:
//   clk, reset (async, active low)
//   i_start/i_op/i_a/i_b : operation request and operands, sampled when accepted in IDLE
//   i_flush              : aborts any operation in flight, blocks an accept in the same cycle
//   o_stall              : combinational pipeline hold
//   o_valid/o_result     : one-cycle result pulse and registered result
//   o_busy               : FSM not in IDLE
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [5:0]       LAST_IT  = 6'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] result_q, result_d;

    // ------------------------------------------------------------------
    // Accept decode and special-case detection on the incoming operands
    // ------------------------------------------------------------------
    logic             accept;
    logic             acc_signed;
    logic             acc_div0;
    logic             acc_ovf;
    logic             acc_special;
    logic [WIDTH-1:0] acc_mag_a;
    logic [WIDTH-1:0] acc_spec_res;

    always_comb begin
        accept      = (state_q == S_IDLE) && i_start && !i_flush;
        // funct3[0]=0 selects the signed variants (DIV, REM)
        acc_signed  = !i_op[0];
        acc_div0    = (i_b == '0);
        acc_ovf     = acc_signed && (i_a == INT_MIN) && (i_b == ALL_ONES);
        acc_special = acc_div0 || acc_ovf;
        acc_mag_a   = (acc_signed && i_a[WIDTH-1]) ? (-i_a) : i_a;

        // Divide-by-zero takes priority; overflow cannot coincide with it anyway.
        if (acc_div0) begin
            acc_spec_res = i_op[1] ? i_a : ALL_ONES;
        end else begin
            acc_spec_res = i_op[1] ? '0 : INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Restoring shift-subtract step on the latched operand magnitudes
    // ------------------------------------------------------------------
    logic             op_signed;
    logic             op_is_rem;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             step_ok;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic             neg_quo;
    logic             neg_rem;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    always_comb begin
        op_signed = !op_q[0];
        op_is_rem = op_q[1];
        mag_b     = (op_signed && b_q[WIDTH-1]) ? (-b_q) : b_q;

        // Bring the next dividend bit into the partial remainder; the extra
        // top bit keeps the shifted value exact before the trial subtract.
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, mag_b};
        step_ok   = !diff[WIDTH];
        quo_step  = {quo_q[WIDTH-2:0], step_ok};
        rem_step  = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

        // Quotient is negative when signs differ; remainder follows the dividend.
        neg_quo   = op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem   = op_signed && a_q[WIDTH-1];
        q_fin     = neg_quo ? (-quo_step) : quo_step;
        r_fin     = neg_rem ? (-rem_step) : rem_step;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = acc_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_IT) begin
                    state_d = S_DONE;
                end
            end
            // DONE is a single cycle whether or not it is flushed.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_busy   = (state_q != S_IDLE);
        // Gated by reset so a held i_start cannot raise stall while in reset.
        o_stall  = reset && ((accept) || (state_q == S_CALC));
        o_valid  = (state_q == S_DONE) && !i_flush;
        o_result = result_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;

        if (accept) begin
            op_d  = i_op;
            a_d   = i_a;
            b_d   = i_b;
            cnt_d = '0;
            quo_d = acc_mag_a;
            rem_d = '0;
            if (acc_special) begin
                result_d = acc_spec_res;
            end
        end else if ((state_q == S_CALC) && !i_flush) begin
            cnt_d = cnt_q + 6'd1;
            quo_d = quo_step;
            rem_d = rem_step;
            // Final iteration: result register loads as DONE is entered.
            if (cnt_q == LAST_IT) begin
                result_d = op_is_rem ? r_fin : q_fin;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed vectors feed a result scoreboard checked by an independent monitor.
// Latency: each vector's expected o_valid cycle is pushed with its expected result.
// Backpressure: stall duration is counted per vector and compared with the expected latency.
module tb_div_seq;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_busy;

    int checks;
    int errors;
    int cyc;

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_stall  (o_stall),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        #2;
        if (reset && o_valid) begin
            if (exp_res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=0x%08h expected=no_result (t=%0t)", o_result, $time);
            end else begin
                logic [31:0] er;
                int          ec;
                er = exp_res_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("result", o_result, er);
                chk("valid_cycle", 32'(cyc), 32'(ec));
                chk("stall_in_done", {31'd0, o_stall}, 32'd0);
            end
        end
    end

    // Issue one op, drop i_start after the accept cycle, count stalled cycles
    // until o_valid, and check the count equals the expected latency.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit now);
        int stalls;
        bit done;
        if (!now) @(negedge clk);
        i_op = op;
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        exp_res_q.push_back(exp);
        exp_cyc_q.push_back(cyc + lat);
        stalls = 0;
        done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            #2;
            if (o_stall) stalls++;
            if (o_valid) done = 1;
            if (!done) begin
                @(negedge clk);
                if (k == 0) i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        chk("completed", {31'd0, done}, 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(lat));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        i_start = 1'b0;
        i_op = 2'b00;
        i_a = '0;
        i_b = '0;
        i_flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Normal path, accept right on the first edge after release
        do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        do_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
        do_op(OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
        do_op(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
        do_op(OP_REM,  32'd7, 32'hFFFFFFFE, 32'd1, 33, 1'b0);
        do_op(OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33, 1'b0);
        do_op(OP_REM,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 1'b0);
        do_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b0);
        do_op(OP_REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 33, 1'b0);
        do_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 1'b0);
        do_op(OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 1'b0);

        // Special cases
        do_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        do_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        do_op(OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        do_op(OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 1'b0);
        do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
        do_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);

        // Flush at CALC iteration 10 (cycle accept+11); no result for this op
        @(negedge clk);
        i_op = OP_DIVU;
        i_a = 32'd1000;
        i_b = 32'd3;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        i_flush = 1'b1;
        #2;
        chk("flush_calc_valid", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #2;
        chk("flush_busy_after", {31'd0, o_busy}, 32'd0);
        chk("flush_stall_after", {31'd0, o_stall}, 32'd0);
        do_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1'b1);

        // Start and flush together in IDLE: flush wins
        @(negedge clk);
        i_op = OP_DIVU;
        i_a = 32'd8;
        i_b = 32'd0;
        i_start = 1'b1;
        i_flush = 1'b1;
        #2;
        chk("idle_flush_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        i_flush = 1'b0;
        #2;
        chk("idle_flush_busy", {31'd0, o_busy}, 32'd0);

        // Asynchronous reset mid-CALC, between clock edges
        @(negedge clk);
        i_op = OP_DIVU;
        i_a = 32'd9;
        i_b = 32'd3;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stall", {31'd0, o_stall}, 32'd0);
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_result", o_result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);

        // i_start held through DONE: one pulse, re-accept in the cycle after DONE
        @(negedge clk);
        i_op = OP_DIVU;
        i_a = 32'd5;
        i_b = 32'd0;
        i_start = 1'b1;
        exp_res_q.push_back(32'hFFFFFFFF);
        exp_cyc_q.push_back(cyc + 1);
        @(negedge clk);
        #2;
        chk("hold_done_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_done_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        i_op = OP_REMU;
        exp_res_q.push_back(32'd5);
        exp_cyc_q.push_back(cyc + 1);
        #2;
        chk("hold_reaccept_stall", {31'd0, o_stall}, 32'd1);
        chk("hold_reaccept_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_empty", 32'(exp_res_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends with a summary
    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = reset.
REQ-004 i_start  input  1  request from E stage to begin a divide/remainder op.
REQ-005 i_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 i_a  input  32  dividend (rs1), sampled at accept.
REQ-007 i_b  input  32  divisor (rs2), sampled at accept.
REQ-008 i_flush  input  1  E-stage flush; aborts any op in flight.
REQ-009 o_stall  output  1  pipeline hold request (drives the pipeline stall).
REQ-010 o_valid  output  1  result valid, one-cycle pulse.
REQ-011 o_result  output  32  quotient or remainder per i_op.
REQ-012 o_busy  output  1  high while state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 Accept SHALL occur when state is IDLE, i_start=1 and i_flush=0; latch i_op, i_a and i_b; clear the iteration counter.
REQ-015 At accept, if i_b==0 or (signed op and i_a==0x80000000 and i_b==0xFFFFFFFF), next state SHALL be DONE; otherwise it SHALL be CALC.
REQ-016 CALC SHALL run exactly WIDTH iterations of radix-2 restoring shift-subtract on operand magnitudes, one bit per cycle, using a 6-bit counter 0..31; after iteration 31 the next state SHALL be DONE.
REQ-017 Signed ops SHALL divide absolute values; the quotient SHALL be negated when operand signs differ; the remainder SHALL take the dividend's sign.
REQ-018 Divide-by-zero SHALL return quotient 0xFFFFFFFF and remainder i_a (DIV and DIVU alike).
REQ-019 Signed overflow SHALL return quotient 0x80000000 and remainder 0.
REQ-020 o_result SHALL be registered, loaded on entry to DONE, and held until the next DONE entry.
REQ-021 o_stall SHALL equal (IDLE & i_start & ~i_flush) | CALC; it SHALL be combinational so the accept cycle stalls, and it SHALL be low in DONE.
REQ-022 o_valid SHALL equal DONE & ~i_flush; DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency from the accept cycle N: o_valid SHALL assert at N+33 for the normal path and at N+1 for special cases.
REQ-024 i_start outside IDLE SHALL be ignored; a back-to-back start is accepted in the cycle after DONE, not during DONE.
REQ-025 i_flush in CALC or DONE SHALL force next state IDLE with no o_valid; o_stall SHALL drop in the following cycle.
REQ-026 Simultaneous i_start and i_flush in IDLE: flush SHALL win, with no accept and o_stall=0.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, counter 0, latched operands 0 and o_result 0, so that o_stall, o_valid and o_busy are 0 regardless of clk, including mid-CALC.
REQ-028 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 DIVU 100/7 accepted at cycle 0 -> o_stall high cycles 0-32, o_valid at 33, o_result=14; REMU same operands -> 2.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD, REM -> 1.
REQ-031 DIVU 5/0 -> o_valid at cycle 1, 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM -> 0.
REQ-032 Flush at CALC iteration 10 -> state IDLE next cycle, o_valid never asserts, o_stall=0; a start in the following cycle is accepted and completes correctly.
REQ-033 reset=0 pulsed mid-CALC between clock edges -> all outputs 0 immediately; after release, DIVU 9/3 yields 3 at +33.
REQ-034 Start held high through DONE -> exactly one result pulse; re-accept occurs in the cycle after DONE.
